// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: default width and direction encoding.
`timescale 1ns/1ps
package up_down_counter_pkg;

   // Default counter width; the count range is 0 .. 2**CNT_WIDTH-1.
   localparam int unsigned CNT_WIDTH = 2;

   // Direction encoding on the UpDown line.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_if.sv
// Counter bus: direction request in, current count out.
// The master drives the direction; the counter (slave) returns the count.
`timescale 1ns/1ps
interface up_down_counter_if
   import up_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH
);

   logic             UpDown;   // 1 = count up, 0 = count down
   logic [WIDTH-1:0] cnt_out;  // registered count

   modport master (output UpDown, input  cnt_out);
   modport slave  (input  UpDown, output cnt_out);

endinterface : up_down_counter_if

// File: rtl/up_down_next.sv
// Combinational next-count logic: one step up or down, wrapping modulo 2**WIDTH.
`timescale 1ns/1ps
module up_down_next
   import up_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] cnt_o
);

   // Step the count in the requested direction; natural overflow gives the wrap.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves cnt_o unassigned (no latch).
      cnt_o = cnt_i;
      if (dir_i == DIR_UP) begin
         cnt_o = cnt_i + WIDTH'(1);
      end else begin
         cnt_o = cnt_i - WIDTH'(1);
      end
   end

endmodule : up_down_next

// File: rtl/up_down_counter.sv
// Up/down counter top: holds only the asynchronously reset count register.
// The next value comes from up_down_next; the output is the register itself.
`timescale 1ns/1ps
module up_down_counter
   import up_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,   // asynchronous, active-low
   up_down_counter_if.slave     bus
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   up_down_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .cnt_i (cnt_q),
      .dir_i (bus.UpDown),
      .cnt_o (cnt_d)
   );

   // Count register: cleared immediately by reset, otherwise loads the next count each edge.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.cnt_out = cnt_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter with an expected-value scoreboard queue.
`timescale 1ns/1ps
module tb_up_down_counter;
   import up_down_counter_pkg::*;

   localparam int unsigned W = CNT_WIDTH;

   logic clk;
   logic reset;

   up_down_counter_if #(.WIDTH(W)) bus ();

   up_down_counter #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // 200 ns period, rising edges at 100, 300, 500, ... ns
   initial begin
      clk = 1'b0;
      forever #100 clk = ~clk;
   end

   int unsigned    checks = 0;
   int unsigned    errors = 0;
   logic [W-1:0]   exp_q[$];
   logic [W-1:0]   model_cnt = '0;

   // Compare the DUT count against an expected value.
   task automatic check(input string tag, input logic [W-1:0] expected);
      checks++;
      assert (bus.cnt_out === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, bus.cnt_out, expected, $time);
      end
   endtask

   // Push the expected result of the coming edge, wait for it, then pop and compare.
   task automatic step(input logic dir, input string tag);
      logic [W-1:0] exp_v;
      bus.UpDown = dir;
      if (!reset) begin
         model_cnt = '0;
      end else if (dir == DIR_UP) begin
         model_cnt = W'((int'(model_cnt) + 1) % (1 << W));
      end else begin
         model_cnt = W'((int'(model_cnt) + (1 << W) - 1) % (1 << W));
      end
      exp_q.push_back(model_cnt);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty at %0t", tag, $time);
      end else begin
         exp_v = exp_q.pop_front();
         check(tag, exp_v);
      end
   endtask

   // Global time limit so the run always ends.
   initial begin
      #90000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      bus.UpDown = DIR_DOWN;

      // 1. Async reset at 450 ns, then hold through three edges.
      #450;
      reset = 1'b0;
      model_cnt = '0;
      #1;
      check("async_reset", '0);
      step(DIR_DOWN, "reset_hold_500");
      step(DIR_UP,   "reset_hold_700");
      step(DIR_DOWN, "reset_hold_900");

      // 2. Release at 950 ns, count down from 1050 ns: 3,2,1,0,3,2,1.
      #49;
      reset = 1'b1;
      #100;
      for (int i = 0; i < 7; i++) begin
         step(DIR_DOWN, $sformatf("down_%0d", i));
      end

      // 3. Count up from 1: 2,3,0,1.
      #100;
      for (int i = 0; i < 4; i++) begin
         step(DIR_UP, $sformatf("up_%0d", i));
      end

      // 4. Reach 2, then alternate direction with a decoy value mid-cycle: 3,2,3,2.
      step(DIR_UP, "up_to_2");
      for (int i = 0; i < 4; i++) begin
         logic want;
         want = (i % 2 == 0) ? DIR_UP : DIR_DOWN;
         bus.UpDown = ~want;
         #100;
         step(want, $sformatf("toggle_%0d", i));
      end

      // 5. Reach 3, assert reset between edges, release and resume downwards.
      step(DIR_UP, "up_to_3");
      #60;
      bus.UpDown = DIR_UP;
      reset = 1'b0;
      model_cnt = '0;
      #1;
      check("mid_count_reset", '0);
      #60;
      reset = 1'b1;
      step(DIR_DOWN, "resume_down");
      step(DIR_UP,   "resume_up");

      // 6. Hold reset while toggling direction: count stays 0.
      #50;
      reset = 1'b0;
      model_cnt = '0;
      #1;
      check("hold_reset_entry", '0);
      for (int i = 0; i < 4; i++) begin
         step((i % 2 == 0) ? DIR_UP : DIR_DOWN, $sformatf("hold_reset_%0d", i));
      end

      // Release once more: first edge upwards gives 1.
      #50;
      reset = 1'b1;
      step(DIR_UP, "release_up");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_up_down_counter
